// File: rtl/ssd_pkg.sv
`default_nettype none
// ssd_pkg: segment ROM, special glyphs and mode encoding for ssd_scan_ctrl.
// Rev 1.0
package ssd_pkg;

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  localparam logic [7:0] SEG_DASH  = 8'b11111101;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {a,b,c,d,e,f,g,dp}; dp bit is 1 (off) in every entry.
  localparam logic [0:15][7:0] SEG_ROM = {
    8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
    8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
    8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
    8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
  };

  function automatic logic [7:0] seg_encode(input logic [3:0] nib, input logic dp);
    logic [7:0] s;
    s = SEG_ROM[nib];
    return {s[7:1], ~dp};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// bin2bcd_seq: iterative double-dabble, one input bit per cycle, restartable.
// Rev 1.0
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    ClkPort,
  input  logic                    Reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    done,
  output logic                    ovf
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CW    = $clog2(DATA_W + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic [BCD_W:0]    step;

  // Top bit of the result is the bit pushed out of the most significant digit.
  function automatic logic [BCD_W:0] dabble(input logic [BCD_W-1:0] cur, input logic in_bit);
    logic [BCD_W-1:0] adj;
    adj = cur;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
    return {adj, in_bit};
  endfunction

  // The start edge already performs the first shift, so DATA_W edges finish the job.
  assign step = start ? dabble('0, bin[DATA_W-1]) : dabble(bcd, shreg[DATA_W-1]);

  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      state <= S_IDLE;
      shreg <= '0;
      cnt   <= '0;
      bcd   <= '0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state <= S_RUN;
        shreg <= bin << 1;
        cnt   <= CW'(1);
        bcd   <= step[BCD_W-1:0];
        ovf   <= step[BCD_W];
      end else if (state == S_RUN) begin
        shreg <= shreg << 1;
        bcd   <= step[BCD_W-1:0];
        ovf   <= ovf | step[BCD_W];
        cnt   <= cnt + 1'b1;
        if (cnt == CW'(DATA_W - 1)) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ssd_scan_ctrl: hex/decimal multiplexed seven-segment controller with blanking and guard.
// Rev 1.0
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 32,
  parameter int SCAN_DIV   = 131072,
  parameter int GUARD_CYC  = 16
) (
  input  logic                  ClkPort,
  input  logic                  Reset,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  mode,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  blank_lead,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic [7:0]            cathodes,
  output logic                  busy,
  output logic                  overflow
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
  localparam int PW    = $clog2(SCAN_DIV);
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]                 presc_r;
  logic [IW-1:0]                 idx_r;
  logic [NUM_DIGITS-1:0][3:0]    digits_r;
  logic [NUM_DIGITS-1:0]         dp_r;
  logic [NUM_DIGITS-1:0]         pend_dp_r;
  logic                          ovf_r;
  logic                          busy_r;

  logic                          dec_load;
  logic [EXT_W-1:0]              value_ext;
  logic                          hex_ovf;
  logic [BCD_W-1:0]              conv_bcd;
  logic                          conv_done;
  logic                          conv_ovf;
  logic                          guard;
  logic [NUM_DIGITS-1:0]         blank;
  logic [NUM_DIGITS-1:0]         an_next;
  logic [7:0]                    cat_next;

  assign dec_load  = load && (mode_e'(mode) == MODE_DEC);
  assign value_ext = EXT_W'(value);
  assign hex_ovf   = |(value_ext >> BCD_W);
  assign guard     = (presc_r < PW'(GUARD_CYC));
  assign busy      = busy_r;
  assign overflow  = ovf_r;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .start   (dec_load),
    .bin     (value),
    .bcd     (conv_bcd),
    .done    (conv_done),
    .ovf     (conv_ovf)
  );

  // busy_r gates conv_done so a hex load that aborts a conversion cannot be overwritten later.
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      busy_r    <= 1'b0;
      digits_r  <= '0;
      dp_r      <= '0;
      pend_dp_r <= '0;
      ovf_r     <= 1'b0;
    end else if (load) begin
      if (dec_load) begin
        busy_r    <= 1'b1;
        pend_dp_r <= dp_mask;
      end else begin
        busy_r   <= 1'b0;
        digits_r <= value_ext[BCD_W-1:0];
        dp_r     <= dp_mask;
        ovf_r    <= hex_ovf;
      end
    end else if (conv_done && busy_r) begin
      busy_r   <= 1'b0;
      digits_r <= conv_bcd;
      dp_r     <= pend_dp_r;
      ovf_r    <= conv_ovf;
    end
  end

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (digits_r[i] == 4'd0);
      blank[i]   = zero_above && blank_lead && !ovf_r;
    end
  end

  always_comb begin
    an_next  = '1;
    cat_next = SEG_BLANK;
    if (!guard && !blank[idx_r]) begin
      an_next[idx_r] = 1'b0;
      cat_next       = ovf_r ? SEG_DASH : seg_encode(digits_r[idx_r], dp_r[idx_r]);
    end
  end

  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      presc_r  <= '0;
      idx_r    <= '0;
      anodes   <= '1;
      cathodes <= SEG_BLANK;
    end else begin
      if (presc_r == PW'(SCAN_DIV - 1)) begin
        presc_r <= '0;
        idx_r   <= (idx_r == IW'(NUM_DIGITS - 1)) ? '0 : idx_r + 1'b1;
      end else begin
        presc_r <= presc_r + 1'b1;
      end
      anodes   <= an_next;
      cathodes <= cat_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
`default_nettype none
// tb_ssd_scan_ctrl: scoreboard bench for ssd_scan_ctrl (4 digits, 16-bit, 8-cycle slots).
// Rev 1.0
module tb_ssd_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 16;

  localparam logic [7:0] SEG_TB [16] = '{
    8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
    8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
    8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
    8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
  };

  typedef struct {
    int         digit;
    bit         lit;
    logic [7:0] seg;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] value;
  logic          load;
  logic          mode;
  logic [ND-1:0] dp_mask;
  logic          blank_lead;
  logic [ND-1:0] anodes;
  logic [7:0]    cathodes;
  logic          busy;
  logic          overflow;

  exp_t       sb[$];
  logic [7:0] obs_seg [ND];
  bit         obs_lit [ND];
  int         obs_multi;
  int         obs_incons;
  int         n_cmp;
  int         n_bad;

  ssd_scan_ctrl #(
    .NUM_DIGITS (ND),
    .DATA_W     (DW),
    .SCAN_DIV   (8),
    .GUARD_CYC  (2)
  ) dut (
    .ClkPort    (clk),
    .Reset      (rst),
    .value      (value),
    .load       (load),
    .mode       (mode),
    .dp_mask    (dp_mask),
    .blank_lead (blank_lead),
    .anodes     (anodes),
    .cathodes   (cathodes),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic push_expect(input int d0, input int d1, input int d2, input int d3,
                             input bit ovf, input logic [3:0] dp, input bit blk);
    int dg[4];
    bit zero_above;
    dg = '{d0, d1, d2, d3};
    zero_above = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      exp_t e;
      logic [7:0] s;
      zero_above = zero_above && (dg[i] == 0);
      s = SEG_TB[dg[i]];
      e.digit = i;
      e.lit   = !(blk && !ovf && (i != 0) && zero_above);
      e.seg   = ovf ? 8'b11111101 : {s[7:1], ~dp[i]};
      sb.push_back(e);
    end
  endtask

  task automatic push_hex(input int v, input logic [3:0] dp, input bit blk);
    push_expect(v & 15, (v >> 4) & 15, (v >> 8) & 15, (v >> 12) & 15, 1'b0, dp, blk);
  endtask

  task automatic push_dec(input int v, input logic [3:0] dp, input bit blk);
    push_expect(v % 10, (v / 10) % 10, (v / 100) % 10, (v / 1000) % 10, v > 9999, dp, blk);
  endtask

  task automatic drive_load(input int v, input bit m, input logic [3:0] dp);
    @(negedge clk);
    value   = DW'(v);
    mode    = m;
    dp_mask = dp;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic observe_scan(input int ncyc);
    for (int d = 0; d < ND; d++) begin
      obs_lit[d] = 1'b0;
      obs_seg[d] = 8'h00;
    end
    obs_multi  = 0;
    obs_incons = 0;
    repeat (ncyc) begin
      int low;
      @(negedge clk);
      low = 0;
      for (int d = 0; d < ND; d++) begin
        if (anodes[d] === 1'b0) begin
          low++;
          if (obs_lit[d] && obs_seg[d] !== cathodes) obs_incons++;
          obs_lit[d] = 1'b1;
          obs_seg[d] = cathodes;
        end
      end
      if (low > 1) obs_multi++;
    end
  endtask

  task automatic wait_not_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (anodes !== 4'hF) begin n_bad++; $display("FAIL reset_anodes: got %b expected 1111", anodes); end
    n_cmp++; if (cathodes !== 8'hFF) begin n_bad++; $display("FAIL reset_cathodes: got %b expected 11111111", cathodes); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (anodes === 4'hF && n < 64);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL first_light_delay: got %0d expected 3", n); end
    n_cmp++;
    if (anodes !== 4'b1110 || cathodes !== 8'b00000011) begin
      n_bad++; $display("FAIL first_slot: got anodes=%b cathodes=%b expected 1110 00000011", anodes, cathodes);
    end
    n = 0;
    begin
      logic [3:0] prev;
      prev = anodes;
      do begin
        @(negedge clk);
        n++;
        if (anodes === 4'b1110 && prev !== 4'b1110) break;
        prev = anodes;
      end while (n < 100);
    end
    n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL scan_period: got %0d expected 32", n); end
  endtask

  task automatic test_hex();
    exp_t e;
    drive_load(16'hBEEF, 1'b0, 4'b0010);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL hex_overflow: got %b expected 0", overflow); end
    push_hex(16'hBEEF, 4'b0010, 1'b0);
    observe_scan(40);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs_lit[e.digit] !== e.lit || (e.lit && obs_seg[e.digit] !== e.seg)) begin
        n_bad++; $display("FAIL hex_digit%0d: got lit=%0b seg=%b expected lit=%0b seg=%b",
                          e.digit, obs_lit[e.digit], obs_seg[e.digit], e.lit, e.seg);
      end
    end
    n_cmp++;
    if (obs_multi !== 0 || obs_incons !== 0) begin
      n_bad++; $display("FAIL hex_scan_integrity: got multi=%0d incons=%0d expected 0 0", obs_multi, obs_incons);
    end
  endtask

  task automatic test_decimal();
    exp_t e;
    int n;
    drive_load(1234, 1'b1, 4'b0000);
    wait_not_busy(n);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL dec_busy_len: got %0d expected 16", n); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL dec_overflow: got %b expected 0", overflow); end
    @(negedge clk);
    push_dec(1234, 4'b0000, 1'b0);
    observe_scan(40);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs_lit[e.digit] !== e.lit || (e.lit && obs_seg[e.digit] !== e.seg)) begin
        n_bad++; $display("FAIL dec_digit%0d: got lit=%0b seg=%b expected lit=%0b seg=%b",
                          e.digit, obs_lit[e.digit], obs_seg[e.digit], e.lit, e.seg);
      end
    end
  endtask

  task automatic test_dec_overflow();
    exp_t e;
    int n;
    logic ovf_during;
    drive_load(65535, 1'b1, 4'b1111);
    ovf_during = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      ovf_during = ovf_during | overflow;
      @(negedge clk);
    end
    n_cmp++; if (ovf_during !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b expected 0", ovf_during); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    @(negedge clk);
    push_dec(65535, 4'b1111, 1'b0);
    observe_scan(40);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs_lit[e.digit] !== e.lit || (e.lit && obs_seg[e.digit] !== e.seg)) begin
        n_bad++; $display("FAIL ovf_digit%0d: got lit=%0b seg=%b expected lit=%0b seg=%b",
                          e.digit, obs_lit[e.digit], obs_seg[e.digit], e.lit, e.seg);
      end
    end
    drive_load(16'h0042, 1'b0, 4'b0000);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    push_hex(16'h0042, 4'b0000, 1'b0);
    observe_scan(40);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs_lit[e.digit] !== e.lit || (e.lit && obs_seg[e.digit] !== e.seg)) begin
        n_bad++; $display("FAIL hex42_digit%0d: got lit=%0b seg=%b expected lit=%0b seg=%b",
                          e.digit, obs_lit[e.digit], obs_seg[e.digit], e.lit, e.seg);
      end
    end
  endtask

  task automatic test_blanking();
    exp_t e;
    blank_lead = 1'b1;
    drive_load(16'h0007, 1'b0, 4'b0000);
    push_hex(16'h0007, 4'b0000, 1'b1);
    observe_scan(40);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs_lit[e.digit] !== e.lit || (e.lit && obs_seg[e.digit] !== e.seg)) begin
        n_bad++; $display("FAIL blank7_digit%0d: got lit=%0b seg=%b expected lit=%0b seg=%b",
                          e.digit, obs_lit[e.digit], obs_seg[e.digit], e.lit, e.seg);
      end
    end
    drive_load(0, 1'b0, 4'b0000);
    push_hex(0, 4'b0000, 1'b1);
    observe_scan(40);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs_lit[e.digit] !== e.lit || (e.lit && obs_seg[e.digit] !== e.seg)) begin
        n_bad++; $display("FAIL blank0_digit%0d: got lit=%0b seg=%b expected lit=%0b seg=%b",
                          e.digit, obs_lit[e.digit], obs_seg[e.digit], e.lit, e.seg);
      end
    end
    blank_lead = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    int shown999;
    bit reloaded;
    n = 0;
    shown999 = 0;
    reloaded = 1'b0;
    drive_load(999, 1'b1, 4'b0000);
    while (busy === 1'b1 && n < 60) begin
      n++;
      if (n == 5 && !reloaded) begin
        value    = DW'(42);
        load     = 1'b1;
        reloaded = 1'b1;
      end else begin
        load = 1'b0;
      end
      if (anodes !== 4'hF && cathodes === 8'b00001001) shown999++;
      @(negedge clk);
    end
    load = 1'b0;
    n_cmp++; if (n !== 21) begin n_bad++; $display("FAIL b2b_busy_len: got %0d expected 21", n); end
    push_dec(42, 4'b0000, 1'b0);
    observe_scan(40);
    for (int d = 0; d < ND; d++) begin
      if (obs_lit[d] && obs_seg[d] === 8'b00001001) shown999++;
    end
    n_cmp++; if (shown999 !== 0) begin n_bad++; $display("FAIL b2b_999_shown: got %0d samples expected 0", shown999); end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs_lit[e.digit] !== e.lit || (e.lit && obs_seg[e.digit] !== e.seg)) begin
        n_bad++; $display("FAIL b2b_digit%0d: got lit=%0b seg=%b expected lit=%0b seg=%b",
                          e.digit, obs_lit[e.digit], obs_seg[e.digit], e.lit, e.seg);
      end
    end
  endtask

  task automatic test_reset_during_busy();
    exp_t e;
    int busy_seen;
    drive_load(1234, 1'b1, 4'b1111);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstbusy_busy: got %b expected 0", busy); end
    n_cmp++;
    if (anodes !== 4'hF || cathodes !== 8'hFF) begin
      n_bad++; $display("FAIL rstbusy_pins: got anodes=%b cathodes=%b expected 1111 11111111", anodes, cathodes);
    end
    rst = 1'b0;
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL rstbusy_resume: got %0d busy cycles expected 0", busy_seen); end
    push_hex(0, 4'b0000, 1'b0);
    observe_scan(40);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs_lit[e.digit] !== e.lit || (e.lit && obs_seg[e.digit] !== e.seg)) begin
        n_bad++; $display("FAIL rstbusy_digit%0d: got lit=%0b seg=%b expected lit=%0b seg=%b",
                          e.digit, obs_lit[e.digit], obs_seg[e.digit], e.lit, e.seg);
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    value      = '0;
    load       = 1'b0;
    mode       = 1'b0;
    dp_mask    = '0;
    blank_lead = 1'b0;
    test_reset();
    test_hex();
    test_decimal();
    test_dec_overflow();
    test_blanking();
    test_back_to_back();
    test_reset_during_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
